uart_rx_core: RTL and testbench

//  UART receiver: the receive end of the serial link whose transmit pin is muxed by the loopback controller.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_baud_gen.sv | 26 ++
 rtl/uart_rx_core.sv | 137 +++++++++++++
 tb/tb_uart_rx_core.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path and its baud tick generator.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Tick divider rounded to nearest so the bit period error stays within half a clock per tick.
    function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
        int ticks_per_s;
        ticks_per_s = baud_rate * oversample;
        return (clock_rate + ticks_per_s / 2) / ticks_per_s;
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// uart_baud_gen: free-running oversample tick generator, one-cycle en_16x strobe every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk_rx,
    input  logic rst_clk_rx,
    output logic en_16x
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            cnt    <= '0;
            en_16x <= 1'b0;
        end else begin
            en_16x <= (cnt == LAST);
            cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchronizer, oversampled framing FSM, good-byte and error strobes.
// Optional even parity (8E1) is enabled by defining UART_RX_PARITY_EN; default build is 8N1.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       rxd_i,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       par_err
);

    localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

    logic          rxd_m, rxd_s;
    logic          en_16x;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bcnt, bcnt_nxt;
    logic [7:0]    shreg, shreg_nxt, data_nxt;
    logic          pmis, pmis_nxt;
    logic          rdy_nxt, frm_nxt, perr_nxt;

    uart_baud_gen #(.DIV(DIV)) u_baud_gen (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .en_16x     (en_16x)
    );

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd_i;
            rxd_s <= rxd_m;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = en_16x ? cnt + CW'(1) : cnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        pmis_nxt  = pmis;
        data_nxt  = rx_data;
        rdy_nxt   = 1'b0;
        frm_nxt   = 1'b0;
        perr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                bcnt_nxt = '0;
                pmis_nxt = 1'b0;
                if (!rxd_s) state_nxt = START;
            end
            START: if (en_16x && cnt == HALF) begin
                cnt_nxt   = '0;
                state_nxt = rxd_s ? IDLE : DATA;
            end
            DATA: if (en_16x && cnt == FULL) begin
                cnt_nxt   = '0;
                shreg_nxt = {rxd_s, shreg[7:1]};
                bcnt_nxt  = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bcnt == 3'd7) state_nxt = PARITY;
`else
                if (bcnt == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (en_16x && cnt == FULL) begin
                cnt_nxt   = '0;
                pmis_nxt  = rxd_s ^ (^shreg);
                state_nxt = STOP;
            end
`endif
            STOP: if (en_16x && cnt == FULL) begin
                cnt_nxt = '0;
                if (!rxd_s) begin
                    frm_nxt   = 1'b1;
                    state_nxt = WAIT_IDLE;
                end else begin
                    state_nxt = IDLE;
                    if (pmis) begin
                        perr_nxt = 1'b1;
                    end else begin
                        rdy_nxt  = 1'b1;
                        data_nxt = shreg;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with control state; it is tiny and keeps sim X-free.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state       <= IDLE;
            cnt         <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            pmis        <= 1'b0;
            rx_data     <= 8'h00;
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
            par_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bcnt        <= bcnt_nxt;
            shreg       <= shreg_nxt;
            pmis        <= pmis_nxt;
            rx_data     <= data_nxt;
            rx_data_rdy <= rdy_nxt;
            frm_err     <= frm_nxt;
            par_err     <= perr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core at default rates (432 clocks per bit).
module tb_uart_rx_core;

    localparam int BIT_CLKS  = 27 * 16;
    localparam int TICK_CLKS = 27;

    logic       clk_rx = 1'b0;
    logic       rst_clk_rx = 1'b1;
    logic       rxd_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_rdy, frm_err, par_err;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0, par_cnt = 0, wide_cnt = 0, overlap_cnt = 0;
    logic prev_rdy = 1'b0, prev_frm = 1'b0, prev_par = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    uart_rx_core dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .rxd_i       (rxd_i),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .frm_err     (frm_err),
        .par_err     (par_err)
    );

    always #10 clk_rx = ~clk_rx;

    always @(negedge clk_rx) begin
        if (rx_data_rdy) got_q.push_back(rx_data);
        if (frm_err) frm_cnt++;
        if (par_err) par_cnt++;
        if ((rx_data_rdy && prev_rdy) || (frm_err && prev_frm) || (par_err && prev_par)) wide_cnt++;
        if (int'(rx_data_rdy) + int'(frm_err) + int'(par_err) > 1) overlap_cnt++;
        prev_rdy = rx_data_rdy;
        prev_frm = frm_err;
        prev_par = par_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic send_bit(input logic v);
        rxd_i = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop_v);
    endtask

    // Compares every byte strobed out since the last call against what the bench queued.
    task automatic expect_bytes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // 1: reset and quiet idle line
        wait_clks(5);
        rst_clk_rx = 1'b0;
        wait_clks(1);
        check("rst_data", rx_data, 8'h00);
        check("rst_rdy", rx_data_rdy, 1'b0);
        check("rst_frm", frm_err, 1'b0);
        check("rst_par", par_err, 1'b0);
        wait_clks(20 * BIT_CLKS);
        expect_bytes("idle");
        check("idle_frm", frm_cnt, 0);

        // 2: single good byte
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        wait_clks(BIT_CLKS);
        expect_bytes("a5");
        check("a5_hold", rx_data, 8'hA5);
        check("a5_frm", frm_cnt, 0);

        // 3: short low glitch rejected as a false start
        rxd_i = 1'b0;
        wait_clks(3 * TICK_CLKS);
        rxd_i = 1'b1;
        wait_clks(2 * BIT_CLKS);
        expect_bytes("glitch");
        check("glitch_hold", rx_data, 8'hA5);
        check("glitch_frm", frm_cnt, 0);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        wait_clks(BIT_CLKS);
        expect_bytes("3c");

        // 4: framing error followed by a long break
        send_frame(8'h55, 1'b0);
        rxd_i = 1'b0;
        wait_clks(20 * BIT_CLKS);
        rxd_i = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("brk_frm", frm_cnt, 1);
        check("brk_hold", rx_data, 8'h3C);
        expect_bytes("brk");
        send_frame(8'h81, 1'b1);
        exp_q.push_back(8'h81);
        wait_clks(BIT_CLKS);
        expect_bytes("81");
        check("81_frm", frm_cnt, 1);

        // 5: back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h7E, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7E);
        wait_clks(BIT_CLKS);
        expect_bytes("b2b");

        // 6: reset in the middle of data bit 4; the sender is reset too and idles the line
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
        rxd_i = 1'b0;
        wait_clks(BIT_CLKS / 2);
        rst_clk_rx = 1'b1;
        rxd_i = 1'b1;
        wait_clks(2);
        rst_clk_rx = 1'b0;
        wait_clks(12 * BIT_CLKS);
        expect_bytes("abort");
        check("abort_data", rx_data, 8'h00);
        check("abort_frm", frm_cnt, 1);
        send_frame(8'h12, 1'b1);
        exp_q.push_back(8'h12);
        wait_clks(BIT_CLKS);
        expect_bytes("12");

`ifdef UART_RX_PARITY_EN
        bad_par = 1'b1;
        send_frame(8'h01, 1'b1);
        wait_clks(BIT_CLKS);
        check("perr_cnt", par_cnt, 1);
        check("perr_hold", rx_data, 8'h12);
        expect_bytes("perr");
        bad_par = 1'b0;
        send_frame(8'h01, 1'b1);
        exp_q.push_back(8'h01);
        wait_clks(BIT_CLKS);
        expect_bytes("pok");
        check("pok_cnt", par_cnt, 1);
`else
        check("par_tied", par_cnt, 0);
`endif

        check("strobe_width", wide_cnt, 0);
        check("strobe_excl", overlap_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
